// File: rtl/register_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// register_wb_arbiter_if
//   Bundles the writeback requester handshake, the register-file write port and
//   the read-hazard probe of register_wb_arbiter into one interface.
//
//   Signals (NREQ requesters, requester i owns slice i of each vector)
//     req_valid [NREQ]      requester i holds a write
//     req_waddr [NREQ*5]    destination register of requester i
//     req_wdata [NREQ*32]   write data of requester i
//     req_ready [NREQ]      one-hot grant back to the requesters
//     rden1/raddr1          read port 1 enable/address (copy of regfile request)
//     rden2/raddr2          read port 2 enable/address
//     wren/waddr/wdata      staged register-file write port
//     hazard1/hazard2       read port would return stale data this cycle
//
//   Modports
//     master : requester / read-port side (drives requests and read probes)
//     slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface register_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_waddr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;

    logic               rden1;
    logic [4:0]         raddr1;
    logic               rden2;
    logic [4:0]         raddr2;

    logic               wren;
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic               hazard1;
    logic               hazard2;

    modport master (
        output req_valid, req_waddr, req_wdata,
        output rden1, raddr1, rden2, raddr2,
        input  req_ready,
        input  wren, waddr, wdata,
        input  hazard1, hazard2
    );

    modport slave (
        input  req_valid, req_waddr, req_wdata,
        input  rden1, raddr1, rden2, raddr2,
        output req_ready,
        output wren, waddr, wdata,
        output hazard1, hazard2
    );
endinterface

// File: rtl/register_wb_arbiter.sv
// -----------------------------------------------------------------------------
// register_wb_arbiter
//   Shares the single register-file write port among NREQ writeback sources
//   (execute / load / CSR). A round-robin arbiter grants one valid requester per
//   cycle, the winning write is staged for one cycle and driven onto the
//   register-file write port, and both read ports are checked against that
//   staged write to flag stale reads.
//
//   Ports
//     clk  : clock, all state updates on posedge
//     rst  : synchronous reset, active-low
//     bus  : register_wb_arbiter_if.slave (requests, grant, write port, hazards)
// -----------------------------------------------------------------------------
module register_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    register_wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic          any_valid;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    logic          wren_q;
    logic [4:0]    waddr_q;
    logic [31:0]   wdata_q;

    logic [4:0]    addr_arr [NREQ];
    logic [31:0]   data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = bus.req_waddr[5*i +: 5];
        assign data_arr[i] = bus.req_wdata[32*i +: 32];
    end

    // Round-robin search starting at ptr. Walking the offsets from the far end
    // back to ptr lets the last hit be the nearest valid index after ptr.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (bus.req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Grant is masked during reset so no handshake can complete then.
    always_comb begin
        bus.req_ready = '0;
        if (rst && any_valid) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ptr     <= '0;
        end else if (any_valid) begin
            // x0 writes still complete the handshake but never reach the regfile.
            wren_q  <= (addr_arr[winner] != 5'd0);
            waddr_q <= addr_arr[winner];
            wdata_q <= data_arr[winner];
            ptr     <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end else begin
            wren_q  <= 1'b0;
        end
    end

    // A staged write still present when reset is asserted is dropped before the
    // register file can commit it on the reset edge.
    assign bus.wren  = wren_q & rst;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;

    // Only the staged write can make a read stale; x0 always reads as zero.
    assign bus.hazard1 = bus.rden1 & bus.wren & (bus.raddr1 == waddr_q) & (bus.raddr1 != 5'd0);
    assign bus.hazard2 = bus.rden2 & bus.wren & (bus.raddr2 == waddr_q) & (bus.raddr2 != 5'd0);

endmodule

// File: tb/tb_register_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_wb_arbiter
//   Directed scenarios followed by randomized traffic for register_wb_arbiter.
//   A behavioural model (round-robin search over an array of requesters plus a
//   staged-write record) predicts grant, write port and hazards every cycle.
// -----------------------------------------------------------------------------
module tb_register_wb_arbiter;
    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    register_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Requester-side stimulus
    logic        v [NREQ];
    logic [4:0]  a [NREQ];
    logic [31:0] d [NREQ];

    // Reference model state
    int          m_ptr      = 0;
    logic        m_wren     = 1'b0;
    logic [4:0]  m_waddr    = '0;
    logic [31:0] m_wdata    = '0;
    int          last_grant = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]           = v[i];
            bus.req_waddr[5*i +: 5]    = a[i];
            bus.req_wdata[32*i +: 32]  = d[i];
        end
    endtask

    // First valid requester at or after the pointer, wrapping; -1 if none.
    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_now(input string tag);
        int          g;
        logic [63:0] exp_ready;
        logic        exp_wren;
        logic        exp_h1;
        logic        exp_h2;
        g         = rst ? pick() : -1;
        exp_ready = (g < 0) ? 64'd0 : (64'd1 << g);
        exp_wren  = rst && m_wren;
        exp_h1    = exp_wren && bus.rden1 && (bus.raddr1 == m_waddr) && (bus.raddr1 != 5'd0);
        exp_h2    = exp_wren && bus.rden2 && (bus.raddr2 == m_waddr) && (bus.raddr2 != 5'd0);
        check({tag, ".ready"},   64'(bus.req_ready), exp_ready);
        check({tag, ".wren"},    64'(bus.wren),      64'(exp_wren));
        check({tag, ".waddr"},   64'(bus.waddr),     64'(m_waddr));
        check({tag, ".wdata"},   64'(bus.wdata),     64'(m_wdata));
        check({tag, ".hazard1"}, 64'(bus.hazard1),   64'(exp_h1));
        check({tag, ".hazard2"}, 64'(bus.hazard2),   64'(exp_h2));
    endtask

    task automatic edge_step();
        int g;
        g = rst ? pick() : -1;
        @(posedge clk);
        if (!rst) begin
            m_ptr = 0; m_wren = 1'b0; m_waddr = '0; m_wdata = '0; last_grant = -1;
        end else if (g >= 0) begin
            m_wren     = (a[g] != 5'd0);
            m_waddr    = a[g];
            m_wdata    = d[g];
            m_ptr      = (g + 1) % NREQ;
            last_grant = g;
        end else begin
            m_wren     = 1'b0;
            last_grant = -1;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_now(tag);
        edge_step();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        apply();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        bus.rden1 = 1'b0; bus.raddr1 = '0;
        bus.rden2 = 1'b0; bus.raddr2 = '0;
        apply();
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: reset held with every requester valid
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; a[i] = 5'(4 + i); d[i] = 32'h1000 + i;
        end
        apply();
        cycle("t1a");
        cycle("t1b");

        rst = 1'b1;
        clear_reqs();
        cycle("idle");

        // T2: single request from req0
        v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'hDEAD_BEEF;
        apply();
        @(negedge clk);
        check_now("t2_grant");
        check("t2_ready_const", 64'(bus.req_ready), 64'b001);
        edge_step();
        clear_reqs();
        @(negedge clk);
        check_now("t2_staged");
        check("t2_wren",  64'(bus.wren),  64'd1);
        check("t2_waddr", 64'(bus.waddr), 64'd5);
        check("t2_wdata", 64'(bus.wdata), 64'hDEAD_BEEF);
        edge_step();
        @(negedge clk);
        check_now("t2_after");
        check("t2_wren_off", 64'(bus.wren), 64'd0);
        edge_step();

        // Bring the pointer back to 0 with a lone req2 grant
        v[2] = 1'b1; a[2] = 5'd10; d[2] = 32'h0000_00AA;
        apply();
        cycle("pre_t3");

        // T3: all three valid and held -> 0,1,2,0,1,2
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; a[i] = 5'(1 + i); d[i] = 32'h100 + i;
        end
        apply();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_now("t3");
            check("t3_ready_seq", 64'(bus.req_ready), 64'd1 << (c % 3));
            if (c > 0) check("t3_waddr_seq", 64'(bus.waddr), 64'(((c - 1) % 3) + 1));
            edge_step();
        end
        clear_reqs();
        cycle("t3_drain");

        // T4: x0 write from req1 is granted but suppressed, pointer still advances
        v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'h55;
        apply();
        @(negedge clk);
        check_now("t4_grant");
        check("t4_ready", 64'(bus.req_ready), 64'b010);
        edge_step();
        v[1] = 1'b0;
        v[0] = 1'b1; a[0] = 5'd12; d[0] = 32'h1212;
        v[2] = 1'b1; a[2] = 5'd7;  d[2] = 32'h7777;
        apply();
        @(negedge clk);
        check_now("t4_next");
        check("t4_wren_x0",    64'(bus.wren),      64'd0);
        check("t4_next_ready", 64'(bus.req_ready), 64'b100);
        edge_step();
        v[2] = 1'b0;
        apply();

        // T5: hazard against staged write to x7, concurrent grant of req0
        bus.rden1 = 1'b1; bus.raddr1 = 5'd7;
        bus.rden2 = 1'b1; bus.raddr2 = 5'd3;
        @(negedge clk);
        check_now("t5a");
        check("t5_h1",    64'(bus.hazard1),   64'd1);
        check("t5_h2",    64'(bus.hazard2),   64'd0);
        check("t5_ready", 64'(bus.req_ready), 64'b001);
        bus.raddr1 = 5'd0;
        #1;
        check_now("t5b");
        check("t5_h1_x0", 64'(bus.hazard1), 64'd0);
        edge_step();
        v[0] = 1'b0;
        apply();
        bus.rden1 = 1'b0; bus.rden2 = 1'b0;

        // T6: reset right after granting req2 -> staged write to x9 dropped
        v[2] = 1'b1; a[2] = 5'd9; d[2] = 32'h9999;
        apply();
        @(negedge clk);
        check_now("t6_grant");
        check("t6_ready", 64'(bus.req_ready), 64'b100);
        edge_step();
        v[2] = 1'b0;
        apply();
        rst = 1'b0;
        @(negedge clk);
        check_now("t6_rst");
        check("t6_wren_dropped", 64'(bus.wren), 64'd0);
        edge_step();
        rst = 1'b1;
        v[1] = 1'b1; a[1] = 5'd3; d[1] = 32'h3333;
        v[2] = 1'b1; a[2] = 5'd4; d[2] = 32'h4444;
        apply();
        @(negedge clk);
        check_now("t6_release");
        check("t6_lowest", 64'(bus.req_ready), 64'b010);
        check("t6_waddr_rst", 64'(bus.waddr), 64'd0);
        edge_step();
        clear_reqs();
        cycle("t6_drain");

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 29) != 0);
            for (int i = 0; i < NREQ; i++) begin
                // A pending request must be held unchanged until granted.
                if (!(v[i] && last_grant != i)) begin
                    v[i] = 1'($urandom_range(0, 1));
                    a[i] = 5'($urandom_range(0, 7));
                    d[i] = $urandom;
                end
            end
            apply();
            bus.rden1  = 1'($urandom_range(0, 1));
            bus.raddr1 = 5'($urandom_range(0, 7));
            bus.rden2  = 1'($urandom_range(0, 1));
            bus.raddr2 = 5'($urandom_range(0, 7));
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
